// File: rtl/bit_packer_for_output.sv
// Packs LSB-first variable-length code words into bytes for the deflate byte sink.
// Optional: define BIT_PACKER_COUNT_EN to add o_total, the byte count of the current stream.
module bit_packer_for_output #(
  parameter int IN_BITS  = 32,
  parameter int BUF_BITS = 64,
  parameter int LEN_W    = 6
) (
  input  logic               clk,
  input  logic               rstn,
  output logic               i_rdy,
  input  logic               i_en,
  input  logic [IN_BITS-1:0] i_bits,
  input  logic [LEN_W-1:0]   i_len,
  input  logic               i_last,
  input  logic               o_rdy,
  output logic               o_en,
  output logic [7:0]         o_data,
  output logic               o_last
`ifdef BIT_PACKER_COUNT_EN
  ,
  output logic [31:0]        o_total
`endif
);

  localparam int               CNT_W   = $clog2(BUF_BITS + 1);
  localparam logic [CNT_W-1:0] RDY_MAX = CNT_W'(BUF_BITS - IN_BITS);
  localparam logic [CNT_W-1:0] BYTE    = CNT_W'(8);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(IN_BITS);

  typedef enum logic {FILL, FLUSH} state_t;

  state_t              state_q, state_d;
  logic [BUF_BITS-1:0] buf_q, buf_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic                in_fire, out_fire;
  logic [LEN_W-1:0]    len_eff;
  logic [CNT_W-1:0]    take, base;
  logic [BUF_BITS-1:0] word_mask, placed, buf_shift;

  assign i_rdy  = (state_q == FILL) && (cnt_q <= RDY_MAX);
  assign o_en   = (cnt_q >= BYTE) || (state_q == FLUSH);
  assign o_last = (state_q == FLUSH) && (cnt_q <= BYTE);
  // Bits above cnt are zero by construction; the mask makes the pad explicit.
  assign o_data = (cnt_q >= BYTE) ? buf_q[7:0] : (buf_q[7:0] & ~(8'hFF << cnt_q));

  always_comb begin
    // NOTE: every signal written here gets a value before any branch, so no latch is inferred.
    in_fire   = i_en && i_rdy;
    out_fire  = o_en && o_rdy;
    len_eff   = (i_len > LEN_MAX) ? LEN_MAX : i_len;
    take      = (cnt_q >= BYTE) ? BYTE : cnt_q;
    base      = out_fire ? (cnt_q - take) : cnt_q;
    buf_shift = out_fire ? (buf_q >> 8) : buf_q;
    word_mask = ~({BUF_BITS{1'b1}} << len_eff);
    placed    = ({{(BUF_BITS-IN_BITS){1'b0}}, i_bits} & word_mask) << base;
    state_d   = state_q;
    buf_d     = buf_shift;
    cnt_d     = base;
    if (in_fire) begin
      buf_d = buf_shift | placed;
      cnt_d = base + CNT_W'(len_eff);
      if (i_last) state_d = FLUSH;
    end
    // Input is blocked in FLUSH, so this never collides with an input transfer.
    if (out_fire && o_last) begin
      state_d = FILL;
      buf_d   = '0;
      cnt_d   = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples the same cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= FILL;
      buf_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef BIT_PACKER_COUNT_EN
  // done_q remembers that the last byte went out, so the next stream restarts at 1.
  logic done_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      o_total <= '0;
      done_q  <= 1'b0;
    end else if (out_fire) begin
      o_total <= done_q ? 32'd1 : o_total + 32'd1;
      done_q  <= o_last;
    end
  end
`endif

endmodule

// File: tb/tb_bit_packer_for_output.sv
// Directed self-checking bench for bit_packer_for_output (IN_BITS=32, BUF_BITS=64, LEN_W=6).
// Define BIT_PACKER_COUNT_EN for both files to also check o_total.
module tb_bit_packer_for_output;

  logic        clk = 1'b0;
  logic        rstn;
  logic        i_rdy;
  logic        i_en;
  logic [31:0] i_bits;
  logic [5:0]  i_len;
  logic        i_last;
  logic        o_rdy;
  logic        o_en;
  logic [7:0]  o_data;
  logic        o_last;
`ifdef BIT_PACKER_COUNT_EN
  logic [31:0] o_total;
`endif

  int checks = 0;
  int passes = 0;
  logic [9:0] got, exp;

  bit_packer_for_output #(.IN_BITS(32), .BUF_BITS(64), .LEN_W(6)) dut (
    .clk    (clk),
    .rstn   (rstn),
    .i_rdy  (i_rdy),
    .i_en   (i_en),
    .i_bits (i_bits),
    .i_len  (i_len),
    .i_last (i_last),
    .o_rdy  (o_rdy),
    .o_en   (o_en),
    .o_data (o_data),
    .o_last (o_last)
`ifdef BIT_PACKER_COUNT_EN
    ,
    .o_total(o_total)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    i_en = 1'b0; i_bits = '0; i_len = '0; i_last = 1'b0;
  endtask

  task automatic send(input logic [31:0] b, input logic [5:0] l, input logic la);
    i_en = 1'b1; i_bits = b; i_len = l; i_last = la;
  endtask

  task automatic test_reset();
    rstn = 1'b0; o_rdy = 1'b1; idle();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    got = {o_en, o_last, o_data}; exp = 10'h000;
    if (got !== exp) $display("FAIL reset_out: got %h want %h", got, exp); else passes++;
    checks++;
    if (i_rdy !== 1'b1) $display("FAIL reset_irdy: got %b want 1", i_rdy); else passes++;
`ifdef BIT_PACKER_COUNT_EN
    checks++;
    if (o_total !== 32'd0) $display("FAIL reset_total: got %0d want 0", o_total); else passes++;
`endif
    rstn = 1'b1;
    step();
    checks++;
    if (o_en !== 1'b0) $display("FAIL reset_idle_oen: got %b want 0", o_en); else passes++;
  endtask

  // 3+5 bits form 0xB5, then 0xA5 and a zero-length terminator.
  task automatic test_basic_stream();
    send(32'b101, 6'd3, 1'b0);
    step();
    send(32'b10110, 6'd5, 1'b0);
    checks++;
    if (o_en !== 1'b0) $display("FAIL t1_partial_oen: got %b want 0", o_en); else passes++;
    step();
    send(32'hA5, 6'd8, 1'b0);
    checks++;
    got = {o_en, o_last, o_data}; exp = {2'b10, 8'hB5};
    if (got !== exp) $display("FAIL t1_byte0: got %h want %h", got, exp); else passes++;
    step();
    // Hold the sink one cycle so the terminator lands before 0xA5 drains; otherwise a
    // separate 0x00 pad byte would carry o_last.
    o_rdy = 1'b0;
    send(32'h0, 6'd0, 1'b1);
    checks++;
    got = {o_en, o_last, o_data}; exp = {2'b10, 8'hA5};
    if (got !== exp) $display("FAIL t1_byte1_pre: got %h want %h", got, exp); else passes++;
    step();
    o_rdy = 1'b1; idle();
    checks++;
    got = {o_en, o_last, o_data}; exp = {2'b11, 8'hA5};
    if (got !== exp) $display("FAIL t1_byte1_last: got %h want %h", got, exp); else passes++;
    checks++;
    if (i_rdy !== 1'b0) $display("FAIL t1_flush_irdy: got %b want 0", i_rdy); else passes++;
    step();
    checks++;
    got = {o_en, i_rdy, 8'h00}; exp = {2'b01, 8'h00};
    if (got !== exp) $display("FAIL t1_done: got %h want %h", got, exp); else passes++;
  endtask

  task automatic test_pad();
    send(32'hABC, 6'd12, 1'b1);
    step();
    idle();
    checks++;
    got = {o_en, o_last, o_data}; exp = {2'b10, 8'hBC};
    if (got !== exp) $display("FAIL t2_byte0: got %h want %h", got, exp); else passes++;
    step();
    checks++;
    got = {o_en, o_last, o_data}; exp = {2'b11, 8'h0A};
    if (got !== exp) $display("FAIL t2_byte1: got %h want %h", got, exp); else passes++;
    step();
    checks++;
    got = {o_en, i_rdy, 8'h00}; exp = {2'b01, 8'h00};
    if (got !== exp) $display("FAIL t2_done: got %h want %h", got, exp); else passes++;
`ifdef BIT_PACKER_COUNT_EN
    checks++;
    if (o_total !== 32'd2) $display("FAIL t2_total: got %0d want 2", o_total); else passes++;
`endif
  endtask

  task automatic test_empty();
    send(32'h0, 6'd0, 1'b1);
    step();
    idle();
    checks++;
    got = {o_en, o_last, o_data}; exp = {2'b11, 8'h00};
    if (got !== exp) $display("FAIL t3_byte: got %h want %h", got, exp); else passes++;
    step();
    checks++;
    got = {o_en, i_rdy, 8'h00}; exp = {2'b01, 8'h00};
    if (got !== exp) $display("FAIL t3_done: got %h want %h", got, exp); else passes++;
  endtask

  // Bits above i_len are ignored; i_len above 32 counts as 32.
  task automatic test_mask_clamp();
    logic [7:0] bytes [4];
    bytes = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    send(32'hFFFF_FFFF, 6'd4, 1'b1);
    step();
    idle();
    checks++;
    got = {o_en, o_last, o_data}; exp = {2'b11, 8'h0F};
    if (got !== exp) $display("FAIL mask_byte: got %h want %h", got, exp); else passes++;
    step();
    send(32'hDEAD_BEEF, 6'd40, 1'b1);
    step();
    idle();
    for (int k = 0; k < 4; k++) begin
      checks++;
      got = {o_en, o_last, o_data}; exp = {1'b1, (k == 3), bytes[k]};
      if (got !== exp) $display("FAIL clamp_byte%0d: got %h want %h", k, got, exp); else passes++;
      step();
    end
    checks++;
    if (o_en !== 1'b0) $display("FAIL clamp_done: got %b want 0", o_en); else passes++;
  endtask

  task automatic test_backpressure();
    o_rdy = 1'b0;
    send(32'h0403_0201, 6'd32, 1'b0);
    step();
    checks++;
    if (i_rdy !== 1'b1) $display("FAIL bp_irdy_cnt32: got %b want 1", i_rdy); else passes++;
    send(32'h0807_0605, 6'd32, 1'b0);
    step();
    send(32'h0C0B_0A09, 6'd32, 1'b0);
    for (int k = 0; k < 3; k++) begin
      checks++;
      got = {o_en, i_rdy, o_data}; exp = {2'b10, 8'h01};
      if (got !== exp) $display("FAIL bp_hold%0d: got %h want %h", k, got, exp); else passes++;
      step();
    end
    o_rdy = 1'b1;
    // Third word is held on the input and enters once cnt falls back to 32.
    for (int j = 0; j < 12; j++) begin
      checks++;
      got = {o_en, o_last, o_data}; exp = {2'b10, 8'(j + 1)};
      if (got !== exp) $display("FAIL bp_byte%0d: got %h want %h", j, got, exp); else passes++;
      if (j <= 4) begin
        checks++;
        if (i_rdy !== (j == 4)) $display("FAIL bp_irdy%0d: got %b want %b", j, i_rdy, (j == 4));
        else passes++;
      end
      step();
      if (j == 4) idle();
    end
    checks++;
    if (o_en !== 1'b0) $display("FAIL bp_drained: got %b want 0", o_en); else passes++;
`ifdef BIT_PACKER_COUNT_EN
    checks++;
    if (o_total !== 32'd12) $display("FAIL bp_total: got %0d want 12", o_total); else passes++;
`endif
  endtask

  task automatic test_back_to_back();
    o_rdy = 1'b1;
    for (int k = 0; k < 8; k++) begin
      send({24'h0, 8'(8'h11 * (k + 1))}, 6'd8, 1'b0);
      if (k > 0) begin
        checks++;
        got = {o_en, i_rdy, o_data}; exp = {2'b11, 8'(8'h11 * k)};
        if (got !== exp) $display("FAIL b2b_byte%0d: got %h want %h", k, got, exp); else passes++;
      end
      step();
    end
    idle();
    checks++;
    got = {o_en, i_rdy, o_data}; exp = {2'b11, 8'h88};
    if (got !== exp) $display("FAIL b2b_tail: got %h want %h", got, exp); else passes++;
    step();
    checks++;
    if (o_en !== 1'b0) $display("FAIL b2b_empty: got %b want 0", o_en); else passes++;
  endtask

  task automatic test_reset_flush();
    o_rdy = 1'b0;
    send(32'h000F_FFFF, 6'd20, 1'b1);
    step();
    idle();
    checks++;
    got = {o_en, i_rdy, o_data}; exp = {2'b10, 8'hFF};
    if (got !== exp) $display("FAIL rf_pre: got %h want %h", got, exp); else passes++;
    #2 rstn = 1'b0;
    #1;
    checks++;
    got = {o_en, o_last, o_data}; exp = 10'h000;
    if (got !== exp) $display("FAIL rf_out: got %h want %h", got, exp); else passes++;
    checks++;
    if (i_rdy !== 1'b1) $display("FAIL rf_irdy: got %b want 1", i_rdy); else passes++;
`ifdef BIT_PACKER_COUNT_EN
    checks++;
    if (o_total !== 32'd0) $display("FAIL rf_total: got %0d want 0", o_total); else passes++;
`endif
    @(posedge clk);
    #1 rstn = 1'b1;
    o_rdy = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step();
      checks++;
      got = {o_en, i_rdy, o_data}; exp = {2'b01, 8'h00};
      if (got !== exp) $display("FAIL rf_after%0d: got %h want %h", k, got, exp); else passes++;
    end
  endtask

  initial begin
    test_reset();
    test_basic_stream();
    test_pad();
    test_empty();
    test_mask_clamp();
    test_backpressure();
    test_back_to_back();
    test_reset_flush();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
